// File: rtl/rnn_pkg.sv
// Shared definitions for the RNN memory arbiter slice.
//   - default address/data widths
//   - memory select codes driven on msel
//   - arbiter ownership state enumeration
//   - lock counter width and a small sel-decode helper
package rnn_pkg;

  localparam int unsigned AW_DEF     = 17;
  localparam int unsigned DW_DEF     = 20;
  localparam int unsigned LOCK_CNT_W = 7;

  localparam logic [2:0] MSEL_IDLE  = 3'b100;
  localparam logic [2:0] MSEL_WRITE = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  // Every command except a write returns data three cycles after its grant.
  function automatic logic is_read(input logic [2:0] sel);
    return sel != MSEL_WRITE;
  endfunction

endpackage

// File: rtl/rnn_rr_arb2.sv
// Two-way round-robin arbiter with burst lock.
// Ports:
//   clk_i    rising-edge clock
//   reset_i  synchronous active-high reset; forces gnt_o to 0 while high
//   req_i    request per requester
//   lock_i   hold-grant per requester (ignored without the matching req)
//   gnt_o    one-hot (or zero) grant, combinational from state and requests
module rnn_rr_arb2
  import rnn_pkg::*;
#(
  parameter int unsigned LOCK_MAX = 64
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] req_i,
  input  logic [1:0] lock_i,
  output logic [1:0] gnt_o
);

  arb_state_e            state_q, state_d;
  logic                  last_q, last_d;   // id granted most recently
  logic [LOCK_CNT_W-1:0] cnt_q, cnt_d;     // consecutive locked grants while the other waits

  logic [1:0] hold;
  logic       owner_vld;
  logic       owner;
  logic       at_max;
  logic       win;
  logic       gid;

  assign hold      = req_i & lock_i;
  assign owner_vld = (state_q != ST_IDLE);
  assign owner     = (state_q == ST_OWN1);
  assign at_max    = (cnt_q >= LOCK_CNT_W'(LOCK_MAX));

  always_comb begin
    gnt_o = '0;
    win   = 1'b0;
    if (!reset_i) begin
      unique case (req_i)
        2'b01: gnt_o = 2'b01;
        2'b10: gnt_o = 2'b10;
        2'b11: begin
          // A locked owner keeps the grant until the waiting side has
          // been starved LOCK_MAX times; then it gets one forced grant.
          if (owner_vld && hold[owner]) begin
            win = at_max ? ~owner : owner;
          end else begin
            win = ~last_q;
          end
          gnt_o = win ? 2'b10 : 2'b01;
        end
        default: gnt_o = '0;
      endcase
    end
  end

  always_comb begin
    gid     = gnt_o[1];
    state_d = ST_IDLE;
    last_d  = last_q;
    cnt_d   = '0;
    if (|gnt_o) begin
      state_d = gid ? ST_OWN1 : ST_OWN0;
      last_d  = gid;
      // The first locked grant of a new owner already counts as one.
      if (hold[gid] && req_i[~gid]) begin
        cnt_d = (owner_vld && (owner == gid)) ? cnt_q + 1'b1 : LOCK_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/rnn_mem_arbiter.sv
// Two-requester memory arbiter for the RNN datapath.
// Ports:
//   clk, reset                       rising-edge clock, synchronous active-high reset
//   rN_req, rN_lock                  request / hold grant for a burst (N=0,1)
//   rN_sel, rN_addr, rN_wdata        per-requester command fields
//   rN_gnt                           combinational grant this cycle
//   rN_rvalid                        read data valid for requester N
//   rdata                            registered memory read data (shared)
//   mce, msel, maddr, mdata_w        registered memory command (one cycle after grant)
//   mdata_r                          memory read data, valid the cycle after a command
module rnn_mem_arbiter
  import rnn_pkg::*;
#(
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned LOCK_MAX = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_req,
  input  logic          r0_lock,
  input  logic [2:0]    r0_sel,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  input  logic          r1_req,
  input  logic          r1_lock,
  input  logic [2:0]    r1_sel,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mce,
  output logic [2:0]    msel,
  output logic [AW-1:0] maddr,
  output logic [DW-1:0] mdata_w,
  input  logic [DW-1:0] mdata_r
);

  logic [1:0] gnt;

  rnn_rr_arb2 #(
    .LOCK_MAX (LOCK_MAX)
  ) u_arb (
    .clk_i   (clk),
    .reset_i (reset),
    .req_i   ({r1_req, r0_req}),
    .lock_i  ({r1_lock, r0_lock}),
    .gnt_o   (gnt)
  );

  assign r0_gnt = gnt[0];
  assign r1_gnt = gnt[1];

  // Granted command fields
  logic          gid;
  logic [2:0]    sel_mux;
  logic [AW-1:0] addr_mux;
  logic [DW-1:0] wdata_mux;

  assign gid       = gnt[1];
  assign sel_mux   = gid ? r1_sel   : r0_sel;
  assign addr_mux  = gid ? r1_addr  : r0_addr;
  assign wdata_mux = gid ? r1_wdata : r0_wdata;

  // Command register
  logic          mce_q, mce_d;
  logic [2:0]    msel_q, msel_d;
  logic [AW-1:0] maddr_q, maddr_d;
  logic [DW-1:0] mdata_w_q, mdata_w_d;

  // Read-return pipeline: stage 1 aligns with the command on the bus,
  // stage 2 with mdata_r, and the rvalid register with rdata.
  logic          rd1_v_q, rd1_v_d;
  logic          rd1_id_q, rd1_id_d;
  logic          rd2_v_q;
  logic          rd2_id_q;
  logic [1:0]    rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q;

  always_comb begin
    mce_d     = 1'b0;
    msel_d    = MSEL_IDLE;
    maddr_d   = '0;
    mdata_w_d = mdata_w_q;
    rd1_v_d   = 1'b0;
    rd1_id_d  = 1'b0;
    if (|gnt) begin
      mce_d     = 1'b1;
      msel_d    = sel_mux;
      maddr_d   = addr_mux;
      mdata_w_d = wdata_mux;
      rd1_v_d   = is_read(sel_mux);
      rd1_id_d  = gid;
    end
  end

  always_comb begin
    rvalid_d = '0;
    if (rd2_v_q) begin
      rvalid_d[rd2_id_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mce_q     <= 1'b0;
      msel_q    <= MSEL_IDLE;
      maddr_q   <= '0;
      mdata_w_q <= '0;
      rd1_v_q   <= 1'b0;
      rd1_id_q  <= 1'b0;
      rd2_v_q   <= 1'b0;
      rd2_id_q  <= 1'b0;
      rvalid_q  <= '0;
      rdata_q   <= '0;
    end else begin
      mce_q     <= mce_d;
      msel_q    <= msel_d;
      maddr_q   <= maddr_d;
      mdata_w_q <= mdata_w_d;
      rd1_v_q   <= rd1_v_d;
      rd1_id_q  <= rd1_id_d;
      rd2_v_q   <= rd1_v_q;
      rd2_id_q  <= rd1_id_q;
      rvalid_q  <= rvalid_d;
      rdata_q   <= mdata_r;
    end
  end

  assign mce       = mce_q;
  assign msel      = msel_q;
  assign maddr     = maddr_q;
  assign mdata_w   = mdata_w_q;
  assign rdata     = rdata_q;
  assign r0_rvalid = rvalid_q[0];
  assign r1_rvalid = rvalid_q[1];

endmodule
